// File: rtl/stopwatch_up_pkg.sv
// Shared types and digit limits for the mm:ss up-counting stopwatch.
package stopwatch_up_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [DIGIT_W-1:0] SEC_U = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_T = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_U = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_T = 4'd5;

endpackage

// File: rtl/stopwatch_up_uc_digit.sv
// Single BCD digit up counter; reloads 0 at its limit and ripples carry combinationally.
module uc_digit
  import stopwatch_up_pkg::*;
(
  input  logic               clk_1hz,
  input  logic               rst,
  input  logic               increase,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] value,
  output logic               carry
);

  logic [DIGIT_W-1:0] value_q, value_d;
  logic               at_limit_c;

  always_comb begin
    at_limit_c = (value_q == limit);
    carry      = increase && at_limit_c;
    value_d    = value_q;
    if (clear) begin
      value_d = '0;
    end else if (increase) begin
      value_d = at_limit_c ? '0 : value_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/stopwatch_up.sv
// mm:ss stopwatch: IDLE/RUN/PAUSE/DONE control, four chained BCD digits, wrap or saturate at 59:59.
module stopwatch_up
  import stopwatch_up_pkg::*;
(
  input  logic               clk_1hz,
  input  logic               rst,
  input  logic               start_pause,
  input  logic               clear,
  input  logic               wrap_en,
  output logic [DIGIT_W-1:0] value0,
  output logic [DIGIT_W-1:0] value1,
  output logic [DIGIT_W-1:0] value2,
  output logic [DIGIT_W-1:0] value3,
  output logic               carry_out,
  output logic               running,
  output logic               done
);

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   done_q, done_d;
  logic   carry_out_q, carry_out_d;
  logic   increase_c, at_max_c, saturate_c, digit_inc_c;
  logic   carry0, carry1, carry2, carry3;

  // Saturation suppresses the increment so the display holds 59:59 while entering DONE.
  always_comb begin
    increase_c  = (state_q == RUN) && !start_pause && !clear;
    at_max_c    = (value3 == MIN_T) && (value2 == MIN_U) &&
                  (value1 == SEC_T) && (value0 == SEC_U);
    saturate_c  = at_max_c && !wrap_en;
    digit_inc_c = increase_c && !saturate_c;
  end

  uc_digit u_sec_u (
    .clk_1hz (clk_1hz), .rst (rst), .increase (digit_inc_c), .clear (clear),
    .limit (SEC_U), .value (value0), .carry (carry0)
  );

  uc_digit u_sec_t (
    .clk_1hz (clk_1hz), .rst (rst), .increase (carry0), .clear (clear),
    .limit (SEC_T), .value (value1), .carry (carry1)
  );

  uc_digit u_min_u (
    .clk_1hz (clk_1hz), .rst (rst), .increase (carry1), .clear (clear),
    .limit (MIN_U), .value (value2), .carry (carry2)
  );

  uc_digit u_min_t (
    .clk_1hz (clk_1hz), .rst (rst), .increase (carry2), .clear (clear),
    .limit (MIN_T), .value (value3), .carry (carry3)
  );

  // Next state; clear wins over every other command.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_pause) state_d = RUN;
        RUN:     if (start_pause) state_d = PAUSE;
                 else if (saturate_c) state_d = DONE;
        PAUSE:   if (start_pause) state_d = RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    running_d   = (state_d == RUN);
    done_d      = (state_d == DONE);
    carry_out_d = carry3;
  end

  always_ff @(posedge clk_1hz or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign running   = running_q;
  assign done      = done_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up: count, minute carry, wrap, saturate, pause, clear, async reset.
module tb_stopwatch_up;

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b1;
  logic       start_pause = 1'b0;
  logic       clear = 1'b0;
  logic       wrap_en = 1'b1;
  logic [3:0] value0, value1, value2, value3;
  logic       carry_out, running, done;

  int n_cmp = 0;
  int n_bad = 0;

  stopwatch_up dut (
    .clk_1hz     (clk_1hz),
    .rst         (rst),
    .start_pause (start_pause),
    .clear       (clear),
    .wrap_en     (wrap_en),
    .value0      (value0),
    .value1      (value1),
    .value2      (value2),
    .value3      (value3),
    .carry_out   (carry_out),
    .running     (running),
    .done        (done)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1hz);
      #1;
    end
  endtask

  task automatic pulse_sp();
    start_pause = 1'b1;
    tick(1);
    start_pause = 1'b0;
  endtask

  // Checks the {mm:ss} display plus carry_out/running/done in one go.
  task automatic chk(input string tag, input logic [15:0] exp_disp,
                     input logic exp_co, input logic exp_run, input logic exp_done);
    logic [15:0] disp;
    disp = {value3, value2, value1, value0};
    n_cmp++;
    assert (disp === exp_disp) else begin
      n_bad++;
      $error("FAIL %s display got %h exp %h", tag, disp, exp_disp);
    end
    n_cmp++;
    assert ({carry_out, running, done} === {exp_co, exp_run, exp_done}) else begin
      n_bad++;
      $error("FAIL %s co/run/done got %b exp %b", tag,
             {carry_out, running, done}, {exp_co, exp_run, exp_done});
    end
  endtask

  initial begin
    #12;
    chk("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("idle_wait", 16'h0000, 1'b0, 1'b0, 1'b0);

    pulse_sp();
    chk("enter_run", 16'h0000, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("first_inc", 16'h0001, 1'b0, 1'b1, 1'b0);
    tick(9);
    chk("ten_sec", 16'h0010, 1'b0, 1'b1, 1'b0);

    tick(49);
    chk("at_0059", 16'h0059, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("minute_carry", 16'h0100, 1'b0, 1'b1, 1'b0);

    tick(3599 - 60);
    chk("wrap_at_5959", 16'h5959, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("wrap_to_0000", 16'h0000, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk("wrap_co_pulse", 16'h0001, 1'b0, 1'b1, 1'b0);

    wrap_en = 1'b0;
    tick(3598);
    chk("sat_at_5959", 16'h5959, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("sat_done", 16'h5959, 1'b0, 1'b0, 1'b1);
    tick(3);
    chk("done_hold", 16'h5959, 1'b0, 1'b0, 1'b1);
    pulse_sp();
    chk("done_ignore_sp", 16'h5959, 1'b0, 1'b0, 1'b1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("done_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("idle_after_clear", 16'h0000, 1'b0, 1'b0, 1'b0);

    pulse_sp();
    tick(7);
    chk("at_0007", 16'h0007, 1'b0, 1'b1, 1'b0);
    pulse_sp();
    chk("pause_enter", 16'h0007, 1'b0, 1'b0, 1'b0);
    tick(5);
    chk("pause_hold", 16'h0007, 1'b0, 1'b0, 1'b0);
    pulse_sp();
    chk("resume", 16'h0007, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("resume_inc", 16'h0008, 1'b0, 1'b1, 1'b0);

    tick(754 - 8);
    chk("at_1234", 16'h1234, 1'b0, 1'b1, 1'b0);
    clear = 1'b1;
    start_pause = 1'b1;
    tick(1);
    clear = 1'b0;
    start_pause = 1'b0;
    chk("clear_beats_sp", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("idle_after_both", 16'h0000, 1'b0, 1'b0, 1'b0);

    pulse_sp();
    tick(5);
    chk("recount", 16'h0005, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    tick(3);
    chk("post_rst_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_up.md
STOPWATCH_UP -- requirements
Module: stopwatch_up

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk_1hz and rst.
REQ-002 Parameter: none; all limits SHALL come from the shared package.
REQ-003 clk_1hz  input  1  count clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start_pause  input  1  one-cycle command pulse that toggles between counting and holding.
REQ-006 clear  input  1  one-cycle command pulse that zeroes all digits and returns to IDLE.
REQ-007 wrap_en  input  1  rollover mode: 1 = wrap 59:59->00:00; 0 = stop at 59:59.
REQ-008 value0  output  4  seconds units, BCD 0-9.
REQ-009 value1  output  4  seconds tens, BCD 0-5.
REQ-010 value2  output  4  minutes units, BCD 0-9.
REQ-011 value3  output  4  minutes tens, BCD 0-5.
REQ-012 carry_out  output  1  one-cycle pulse after a 59:59->00:00 wrap.
REQ-013 running  output  1  high while state == RUN.
REQ-014 done  output  1  high while state == DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-016 Transitions SHALL be:
- IDLE -start_pause-> RUN
- RUN -start_pause-> PAUSE
- PAUSE -start_pause-> RUN
- RUN -(at 59:59, wrap_en=0)-> DONE
- any state -clear-> IDLE
REQ-017 clear SHALL take priority over start_pause when both are asserted in the same cycle.
REQ-018 start_pause SHALL be ignored in DONE; only clear or rst SHALL leave DONE.
REQ-019 increase SHALL be defined as: state == RUN and start_pause == 0 and clear == 0; the digits SHALL advance by one at each edge where increase is high.
REQ-020 On the edge that enters RUN, no increment SHALL occur; the first increment SHALL occur on the following edge (latency 1).
REQ-021 Each digit SHALL increment when its carry-in is high. When the digit equals its limit, it SHALL reload 0 and assert its carry to the next digit combinationally in the same cycle.
REQ-022 The carry-in of value0 SHALL be increase; the carry-in of each higher digit SHALL be the carry-out of the digit below it.
REQ-023 When wrap_en=1 and 59:59 is reached with increase high, all digits SHALL become 0 at the next edge, and carry_out SHALL be high for exactly the following cycle.
REQ-024 When wrap_en=0, 59:59 is reached and state == RUN, the next edge SHALL hold 59:59 and enter DONE; carry_out SHALL stay 0.
REQ-025 Digit values SHALL never leave their BCD ranges (value0/value2 in 0-9, value1/value3 in 0-5).
REQ-026 PAUSE SHALL hold all digits unchanged.
REQ-027 clear SHALL zero all digits and carry_out at the next edge, in any state.
REQ-028 A change of wrap_en SHALL take effect at the next edge, with no other side effect.

Reset
REQ-029 While rst=1, the block SHALL hold: state IDLE, value0-value3 = 0, carry_out = 0, running = 0, done = 0.
REQ-030 rst SHALL act immediately (asynchronously) and SHALL override any operation in progress, including mid-carry.
REQ-031 After rst deasserts, the block SHALL wait in IDLE for start_pause.

Structure
REQ-032 A shared package SHALL hold:
- the state typedef/encoding: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
- the digit-limit constants: SEC_U = 9, SEC_T = 5, MIN_U = 9, MIN_T = 5.
REQ-033 One sub-module, uc_digit, SHALL be instantiated four times. It SHALL be the single-digit up counter with ports clk_1hz, rst, increase, clear, limit[3:0], value[3:0], carry.
REQ-034 The FSM, the wrap/saturate decision and the carry_out register SHALL reside in stopwatch_up.

Verification
REQ-035 Scenario: rst pulse, then start_pause at edge 1 -> value0 = 0 at edge 1, 1 at edge 2; after 10 run edges, value1:value0 = 1:0.
REQ-036 Scenario: run to 00:59 -> next edge gives 01:00, with value1 reloaded 0 and value2 = 1 in the same edge.
REQ-037 Scenario: wrap_en=1, reach 59:59, one more edge -> 00:00, carry_out = 1 for one cycle, running stays 1.
REQ-038 Scenario: wrap_en=0, reach 59:59 -> next edge done = 1, running = 0, display 59:59; start_pause then ignored; clear -> 00:00 and IDLE.
REQ-039 Scenario: at 00:07, start_pause -> PAUSE holding 00:07 for 5 edges; start_pause again -> RUN, 00:08 one edge later.
REQ-040 Scenario: clear and start_pause in the same cycle while in RUN at 12:34 -> 00:00 and IDLE; rst asserted mid-count -> immediate zero without waiting for a clock edge.
